mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- MEM pipeline stage placed between ex_mem and mem_wb.
- Drives the mem_* inputs of mem_wb and passes ALU/HILO results through unchanged.
- Performs MIPS load/store accesses over a request/acknowledge data bus of variable latency.
- Raises stallreq_mem to ctrl while an access is outstanding.

Parameters:
- ACK_TIMEOUT, 0, cycles to wait for dbus_ack before asserting bus_err and abandoning the access; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- wreg_i  in  1  GPR write enable from ex_mem
- wd_i  in  5  GPR destination (`RegAddrBus)
- wdata_i  in  32  ALU result
- whilo_i  in  1  HI/LO write enable
- hi_i  in  32  HI value
- lo_i  in  32  LO value
- aluop_i  in  8  operation code (`EXE_*_OP)
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- stall  in  6  ctrl stall vector
- flush  in  1  pipeline flush
- mem_wreg  out  1  to mem_wb
- mem_wd  out  5  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_whilo  out  1  to mem_wb
- mem_hi  out  32  to mem_wb
- mem_lo  out  32  to mem_wb
- stallreq_mem  out  1  stall request to ctrl
- align_err  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on access timeout
- dbus_req  out  1  bus request
- dbus_we  out  1  1 = write
- dbus_addr  out  32  word address, bits [1:0] forced to 00
- dbus_sel  out  4  byte lanes
- dbus_wdata  out  32  write data
- dbus_rdata  in  32  read data
- dbus_ack  in  1  transfer complete

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, hold register=0, timeout counter=0.
  - dbus_req=0, stallreq_mem=0, align_err=0, bus_err=0.
  - Combinational outputs track their inputs.
- Byte order is big-endian. addr[1:0]=00 selects bits [31:24] and dbus_sel=1000; 11 selects [7:0] and 0001. Halfword: addr[1]=0 selects 1100, addr[1]=1 selects 0011. Word selects 1111.
- Stores replicate the byte or halfword across every lane.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Non-memory aluop: every mem_* output equals its *_i input, combinationally; stallreq_mem=0.
- Memory op:
  - mem_whilo=0.
  - mem_wreg=0 for stores.
  - For loads, mem_wreg=wreg_i and mem_wdata=aligned hold data, valid only in DONE; outside DONE mem_wreg=0.
- Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0):
  - no bus request; mem_wreg=0; stallreq_mem=0.
  - align_err=1 for the cycle in which the op is presented.
- States:
  - IDLE: on a valid aligned memory op, combinationally assert stallreq_mem and dbus_req with address/sel/wdata, then go to WAIT.
  - WAIT:
    - dbus_req and stallreq_mem held at 1, request fields held stable.
    - On dbus_ack: latch dbus_rdata into the hold register, drop dbus_req, go to DONE.
    - stallreq_mem stays 1 in the ack cycle; there is no combinational ack-to-stall path.
  - DONE:
    - stallreq_mem=0; the result is driven from the hold register and mem_wb captures it at the next edge.
    - If stall[4]==`NoStop, go to IDLE.
    - Otherwise stay in DONE and keep driving the result.
  - DRAIN: entered on flush while in WAIT.
    - dbus_req stays 1 and stallreq_mem=1; outputs are a bubble (mem_wreg=0).
    - On dbus_ack, discard the data and go to IDLE.
- Fixed latency: a load acked k cycles after the request (k>=0) reaches mem_wb k+2 edges after it is presented.
- Flush:
  - in IDLE or DONE: go to IDLE at the next edge.
  - in WAIT: go to DRAIN, because an issued bus transfer cannot be cancelled.
  - in the same cycle as ack in WAIT: go to IDLE directly.
- Timeout (ACK_TIMEOUT>0):
  - the counter increments each cycle in WAIT/DRAIN and clears on entry to WAIT.
  - When the counter reaches ACK_TIMEOUT: pulse bus_err, drop dbus_req, go to IDLE, suppress the writeback (mem_wreg=0 for one cycle).
- An asynchronous reset during WAIT drops dbus_req immediately.

Decomposition:
- The `EXE_*_OP codes, `RegBus/`RegAddrBus, `ZeroWord, `NOPRegAddr, `Stop/`NoStop and `WriteEnable/`WriteDisable stay in define.v.
- The state encodings (IDLE/WAIT/DONE/DRAIN, 2 bits) are added there as `Lsu* constants.
- One combinational sub-module, mem_align, generates dbus_sel and store replication and performs load extraction/extension. It is instantiated twice: request side and hold-data side.

Test Plan:
- ADD-type op, wdata_i=0x12345678, wreg_i=1 -> the same cycle mem_wdata=0x12345678, mem_wreg=1, stallreq_mem=0, dbus_req=0.
- LB at addr 0x103, ack after 2 cycles, rdata=0x000000F0 -> dbus_sel=0001, dbus_addr=0x100; stallreq_mem high 3 cycles; mem_wdata=0xFFFFFFF0 in DONE.
- LHU at addr 0x202 with ack in the request cycle (k=0), rdata=0xAAAA8001 -> dbus_sel=0011; mem_wdata=0x00008001; stallreq_mem high exactly 1 cycle.
- SB addr 0x1, reg2_i=0x000000AB, ack after 1 cycle -> dbus_we=1, dbus_sel=0100, dbus_wdata=0xABABABAB; mem_wreg=0 throughout.
- LW addr 0x6 -> align_err pulses, dbus_req=0, stallreq_mem=0, mem_wreg=0.
- LW in WAIT, flush asserted, ack 3 cycles later -> DRAIN: dbus_req held until ack, no writeback, state returns to IDLE.
- Reset pulse (rst=0) mid-WAIT -> dbus_req=0 and stallreq_mem=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - aluop codes for the memory instructions (plus ADD/NOP for reference)
//   - stall polarity constant
//   - LSU state encoding (2 bits, exposed on the lsu_state debug port)
//   - helpers that classify an aluop as load or store
package mem_lsu_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic NO_STOP = 1'b0;
    localparam logic STOP    = 1'b1;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_WAIT  = 2'b01,
        LSU_DONE  = 2'b10,
        LSU_DRAIN = 2'b11
    } lsu_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: purely combinational big-endian lane logic.
//   aluop      : memory operation code
//   addr_lo    : effective address bits [1:0]
//   store_data : register value to be stored
//   load_word  : 32-bit word returned by the bus
//   is_load / is_store : operation class
//   misaligned : halfword on odd address or word not on a 4-byte boundary
//   sel        : byte-lane enables (bit 3 = bits [31:24])
//   wdata      : store data replicated across all lanes
//   ldata      : extracted and sign/zero-extended load result
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        is_load    = is_load_op(aluop);
        is_store   = is_store_op(aluop);
        misaligned = 1'b0;
        sel        = 4'b0000;
        wdata      = store_data;
        ldata      = load_word;

        // Big-endian: address offset 0 is the most significant byte.
        case (addr_lo)
            2'b00:   byte_v = load_word[31:24];
            2'b01:   byte_v = load_word[23:16];
            2'b10:   byte_v = load_word[15:8];
            default: byte_v = load_word[7:0];
        endcase
        half_v = addr_lo[1] ? load_word[15:0] : load_word[31:16];

        case (aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{store_data[7:0]}};
                ldata = (aluop == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{store_data[15:0]}};
                ldata      = (aluop == EXE_LH_OP) ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
            end
            EXE_LW_OP, EXE_SW_OP: begin
                misaligned = (addr_lo != 2'b00);
                sel        = 4'b1111;
                wdata      = store_data;
                ldata      = load_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage with a variable-latency req/ack data bus.
//   Pipeline inputs (wreg_i, wd_i, wdata_i, whilo_i, hi_i, lo_i, aluop_i,
//   mem_addr_i, reg2_i, stall, flush) come from ex_mem / ctrl.
//   mem_* outputs feed mem_wb; stallreq_mem goes to ctrl.
//   align_err / bus_err are single-cycle error pulses.
//   dbus_* is the data bus; lsu_state exposes the FSM state for debug.
//
// Bus handshake: dbus_req rises with a stable address/sel/we/wdata and stays
// high with those fields unchanged until the cycle in which dbus_ack is high;
// that cycle completes the transfer (read data is sampled at its end). The
// request may be acked in the very cycle it first appears. Only a timeout or
// reset withdraws a request without an ack.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        wreg_i,
    input  logic [4:0]  wd_i,
    input  logic [31:0] wdata_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        mem_wreg,
    output logic [4:0]  mem_wd,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq_mem,
    output logic        align_err,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic [1:0]  lsu_state
);

    localparam logic        TIMEOUT_EN  = (ACK_TIMEOUT > 0);
    localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic [29:0] req_addr_q, req_addr_d;
    logic [3:0]  req_sel_q, req_sel_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic        req_we_q, req_we_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    // Request side: decodes the op currently presented by ex_mem.
    logic        req_is_load, req_is_store, req_misaligned;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic [31:0] req_ldata_unused;

    mem_align u_req_align (
        .aluop      (aluop_i),
        .addr_lo    (mem_addr_i[1:0]),
        .store_data (reg2_i),
        .load_word  (32'h0),
        .is_load    (req_is_load),
        .is_store   (req_is_store),
        .misaligned (req_misaligned),
        .sel        (req_sel),
        .wdata      (req_wdata),
        .ldata      (req_ldata_unused)
    );

    // Hold side: extracts the load result from the latched bus word using
    // the op/offset captured at issue time.
    logic        hold_is_load;
    logic [31:0] hold_ldata;
    logic        hold_is_store_unused, hold_misaligned_unused;
    logic [3:0]  hold_sel_unused;
    logic [31:0] hold_wdata_unused;

    mem_align u_hold_align (
        .aluop      (op_q),
        .addr_lo    (addr_lo_q),
        .store_data (32'h0),
        .load_word  (hold_q),
        .is_load    (hold_is_load),
        .is_store   (hold_is_store_unused),
        .misaligned (hold_misaligned_unused),
        .sel        (hold_sel_unused),
        .wdata      (hold_wdata_unused),
        .ldata      (hold_ldata)
    );

    // Only stall[4] (MEM stage hold) matters here.
    logic stall_unused;
    assign stall_unused = ^{stall[5], stall[3:0]};

    logic mem_op, issue, in_flight, timeout_hit;

    assign mem_op      = req_is_load | req_is_store;
    assign issue       = (state_q == LSU_IDLE) && mem_op && !req_misaligned && !flush;
    assign in_flight   = (state_q == LSU_WAIT) || (state_q == LSU_DRAIN);
    // Timeout depends only on the counter, never on dbus_ack.
    assign timeout_hit = TIMEOUT_EN && in_flight && (cnt_q == TIMEOUT_CNT);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        req_sel_d   = req_sel_q;
        req_wdata_d = req_wdata_q;
        req_we_d    = req_we_q;
        op_d        = op_q;
        addr_lo_d   = addr_lo_q;

        case (state_q)
            LSU_IDLE: begin
                if (issue) begin
                    req_addr_d  = mem_addr_i[31:2];
                    req_sel_d   = req_sel;
                    req_wdata_d = req_wdata;
                    req_we_d    = req_is_store;
                    op_d        = aluop_i;
                    addr_lo_d   = mem_addr_i[1:0];
                    cnt_d       = 16'h0;
                    if (dbus_ack) begin
                        hold_d  = dbus_rdata;
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (timeout_hit) begin
                    state_d = LSU_IDLE;
                end else if (dbus_ack) begin
                    hold_d  = dbus_rdata;
                    state_d = flush ? LSU_IDLE : LSU_DONE;
                end else if (flush) begin
                    // The issued transfer cannot be cancelled; wait it out.
                    state_d = LSU_DRAIN;
                end
            end
            LSU_DONE: begin
                if (flush || (stall[4] == NO_STOP)) begin
                    state_d = LSU_IDLE;
                end
            end
            default: begin // LSU_DRAIN
                cnt_d = cnt_q + 16'd1;
                if (timeout_hit || dbus_ack) begin
                    state_d = LSU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LSU_IDLE;
            hold_q      <= 32'h0;
            cnt_q       <= 16'h0;
            req_addr_q  <= 30'h0;
            req_sel_q   <= 4'h0;
            req_wdata_q <= 32'h0;
            req_we_q    <= 1'b0;
            op_q        <= EXE_NOP_OP;
            addr_lo_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_sel_q   <= req_sel_d;
            req_wdata_q <= req_wdata_d;
            req_we_q    <= req_we_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    // Control outputs are gated by reset so a reset mid-access withdraws the
    // request immediately, without waiting for a clock edge.
    assign dbus_req     = rst && (issue || (in_flight && !timeout_hit));
    assign stallreq_mem = dbus_req;
    assign align_err    = rst && (state_q == LSU_IDLE) && mem_op && req_misaligned;
    assign bus_err      = rst && timeout_hit;

    assign dbus_addr  = in_flight ? {req_addr_q, 2'b00} : {mem_addr_i[31:2], 2'b00};
    assign dbus_sel   = in_flight ? req_sel_q   : req_sel;
    assign dbus_wdata = in_flight ? req_wdata_q : req_wdata;
    assign dbus_we    = in_flight ? req_we_q    : req_is_store;
    assign lsu_state  = state_q;

    always_comb begin
        mem_wreg  = wreg_i;
        mem_wd    = wd_i;
        mem_wdata = wdata_i;
        mem_whilo = whilo_i;
        mem_hi    = hi_i;
        mem_lo    = lo_i;
        if (state_q == LSU_DRAIN) begin
            // The flushed instruction's slot is a bubble.
            mem_wreg  = 1'b0;
            mem_wd    = 5'h0;
            mem_wdata = 32'h0;
            mem_whilo = 1'b0;
            mem_hi    = 32'h0;
            mem_lo    = 32'h0;
        end else if ((state_q == LSU_DONE) || mem_op) begin
            mem_whilo = 1'b0;
            mem_wdata = hold_ldata;
            mem_wreg  = (state_q == LSU_DONE) && hold_is_load && wreg_i;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_i = '0;
    logic [31:0] wdata_i = '0;
    logic        whilo_i = 1'b0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic [7:0]  aluop_i = EXE_NOP_OP;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] reg2_i = '0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        dbus_ack = 1'b0;

    logic        mem_wreg, mem_whilo, stallreq_mem, align_err, bus_err;
    logic        dbus_req, dbus_we;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, dbus_addr, dbus_wdata;
    logic [3:0]  dbus_sel;
    logic [1:0]  lsu_state;

    int n_checks = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    mem_lsu #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wreg_i(wreg_i), .wd_i(wd_i), .wdata_i(wdata_i),
        .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .stall(stall), .flush(flush),
        .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .stallreq_mem(stallreq_mem), .align_err(align_err), .bus_err(bus_err),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack), .lsu_state(lsu_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [7:0] op);
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        return 0;
    endfunction

    function automatic bit op_loads(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
               op == EXE_LHU_OP || op == EXE_LW_OP;
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return op == EXE_LB_OP || op == EXE_LH_OP;
    endfunction

    function automatic bit m_misaligned(input logic [7:0] op, input logic [31:0] addr);
        return (addr % op_size(op)) != 0;
    endfunction

    // Lane i (bit i) carries byte offset 3-i in a big-endian word.
    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int off = int'(addr % 4);
        return 4'(((1 << sz) - 1) << (4 - sz - off));
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] data);
        int sz = op_size(op);
        longint unsigned v = longint'(data) & ((64'd1 << (8 * sz)) - 1);
        longint unsigned r = 0;
        for (int i = 0; i < 4 / sz; i++) r = r | (v << (8 * sz * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
        int sz = op_size(op);
        int off = int'(addr % 4);
        longint unsigned mask = (64'd1 << (8 * sz)) - 1;
        longint unsigned v = (longint'(word) >> (8 * (4 - sz - off))) & mask;
        if (op_signed(op) && v >= (mask + 1) / 2) v = v | ~mask;
        return v[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_bubble();
        aluop_i = EXE_NOP_OP; wreg_i = 1'b0; flush = 1'b0; stall = '0; dbus_ack = 1'b0;
    endtask

    task automatic run_alu(input logic [31:0] data);
        aluop_i = EXE_ADD_OP; wreg_i = 1'b1; wd_i = 5'($urandom_range(31, 0));
        wdata_i = data; whilo_i = 1'($urandom); hi_i = $urandom; lo_i = $urandom;
        @(negedge clk);
        check_eq("alu_wdata", mem_wdata, data);
        check_eq("alu_wreg", mem_wreg, 1'b1);
        check_eq("alu_wd", mem_wd, wd_i);
        check_eq("alu_whilo", mem_whilo, whilo_i);
        check_eq("alu_hilo", {mem_hi ^ mem_lo}, hi_i ^ lo_i);
        check_eq("alu_stall", stallreq_mem, 1'b0);
        check_eq("alu_req", dbus_req, 1'b0);
        @(posedge clk); #1;
    endtask

    // Presents one memory op and acts as the bus slave, acking k cycles
    // after the request cycle; holds DONE for done_hold extra cycles.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int k, input int done_hold);
        bit ld = op_loads(op);
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wreg_i = 1'b1;
        wd_i = 5'($urandom_range(31, 1)); wdata_i = $urandom; flush = 1'b0; stall = '0;
        if (m_misaligned(op, addr)) begin
            @(negedge clk);
            check_eq("mis_align_err", align_err, 1'b1);
            check_eq("mis_req", dbus_req, 1'b0);
            check_eq("mis_stall", stallreq_mem, 1'b0);
            check_eq("mis_wreg", mem_wreg, 1'b0);
            @(posedge clk); #1;
            drive_bubble();
            return;
        end
        if (ld) exp_q.push_back(m_load(op, addr, rdata));
        for (int c = 0; c <= k; c++) begin
            dbus_ack = (c == k);
            dbus_rdata = (c == k) ? rdata : $urandom;
            @(negedge clk);
            check_eq("req_req", dbus_req, 1'b1);
            check_eq("req_stall", stallreq_mem, 1'b1);
            check_eq("req_addr", dbus_addr, {addr[31:2], 2'b00});
            check_eq("req_sel", dbus_sel, m_sel(op, addr));
            check_eq("req_we", dbus_we, !ld);
            if (!ld) check_eq("req_wdata", dbus_wdata, m_store(op, reg2));
            check_eq("req_wreg", mem_wreg, 1'b0);
            check_eq("req_align", align_err, 1'b0);
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
        dbus_rdata = $urandom;
        for (int h = 0; h <= done_hold; h++) begin
            stall = (h < done_hold) ? 6'b011111 : 6'b000000;
            @(negedge clk);
            check_eq("done_stall", stallreq_mem, 1'b0);
            check_eq("done_req", dbus_req, 1'b0);
            check_eq("done_wreg", mem_wreg, ld);
            check_eq("done_whilo", mem_whilo, 1'b0);
            if (ld) begin
                check_eq("done_wd", mem_wd, wd_i);
                if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
                else check_eq("done_wdata", mem_wdata, (h == done_hold) ? exp_q.pop_front() : exp_q[0]);
            end
            @(posedge clk); #1;
        end
        drive_bubble();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] ops [9];
        ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP};

        // Reset: aligned LW presented, no request may leak out.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h40; dbus_ack = 1'b0;
        #12;
        check_eq("rst_req", dbus_req, 1'b0);
        check_eq("rst_stall", stallreq_mem, 1'b0);
        check_eq("rst_align", align_err, 1'b0);
        check_eq("rst_buserr", bus_err, 1'b0);
        check_eq("rst_state", lsu_state, LSU_IDLE);
        aluop_i = EXE_ADD_OP; wdata_i = 32'hCAFE0001; #1;
        check_eq("rst_pass", mem_wdata, 32'hCAFE0001);
        drive_bubble();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_alu(32'h12345678);
        run_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h000000F0, 2, 0);
        run_mem(EXE_LHU_OP, 32'h202, 32'h0, 32'hAAAA8001, 0, 0);
        run_mem(EXE_SB_OP,  32'h001, 32'h000000AB, 32'h0, 1, 0);
        run_mem(EXE_LW_OP,  32'h006, 32'h0, 32'h0, 0, 0);
        run_mem(EXE_LH_OP,  32'h300, 32'h0, 32'h8123FFFF, 1, 2);

        // Flush in WAIT -> DRAIN until ack, no writeback.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h44; wreg_i = 1'b1;
        @(negedge clk); check_eq("drn_issue", dbus_req, 1'b1);
        @(posedge clk); #1; flush = 1'b1;
        @(negedge clk); check_eq("drn_wait_req", dbus_req, 1'b1);
        @(posedge clk); #1; drive_bubble();
        for (int c = 0; c < 3; c++) begin
            dbus_ack = (c == 2); dbus_rdata = $urandom;
            @(negedge clk);
            check_eq("drn_req", dbus_req, 1'b1);
            check_eq("drn_stall", stallreq_mem, 1'b1);
            check_eq("drn_addr", dbus_addr, 32'h44);
            check_eq("drn_wreg", mem_wreg, 1'b0);
            check_eq("drn_state", lsu_state, LSU_DRAIN);
            @(posedge clk); #1;
        end
        dbus_ack = 1'b0;
        @(negedge clk);
        check_eq("drn_idle", lsu_state, LSU_IDLE);
        check_eq("drn_req_off", dbus_req, 1'b0);
        check_eq("drn_wreg_off", mem_wreg, 1'b0);
        @(posedge clk); #1;

        // Flush together with ack in WAIT -> straight to IDLE.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h48; wreg_i = 1'b1;
        @(posedge clk); #1; flush = 1'b1; dbus_ack = 1'b1;
        @(posedge clk); #1; drive_bubble();
        @(negedge clk);
        check_eq("fa_state", lsu_state, LSU_IDLE);
        check_eq("fa_wreg", mem_wreg, 1'b0);
        @(posedge clk); #1;

        // Timeout: no ack ever; bus_err pulses TMO+1 cycles after the request.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h50; wreg_i = 1'b1;
        for (int c = 0; c <= TMO + 1; c++) begin
            @(negedge clk);
            check_eq("tmo_err", bus_err, c == TMO + 1);
            check_eq("tmo_req", dbus_req, c != TMO + 1);
            check_eq("tmo_stall", stallreq_mem, c != TMO + 1);
            check_eq("tmo_wreg", mem_wreg, 1'b0);
            @(posedge clk); #1;
        end
        drive_bubble();
        @(negedge clk);
        check_eq("tmo_idle", lsu_state, LSU_IDLE);
        check_eq("tmo_err_off", bus_err, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset mid-WAIT.
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h80; wreg_i = 1'b1;
        @(posedge clk); #1;
        check_eq("ar_wait", lsu_state, LSU_WAIT);
        #2 rst = 1'b0; #1;
        check_eq("ar_req", dbus_req, 1'b0);
        check_eq("ar_stall", stallreq_mem, 1'b0);
        check_eq("ar_state", lsu_state, LSU_IDLE);
        drive_bubble();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] op;
            logic [31:0] a;
            op = ops[$urandom_range(8, 0)];
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = (op_size(op) == 4) ? 2'b00 :
                                              (op_size(op) == 2) ? {a[1], 1'b0} : a[1:0];
            if (op == EXE_ADD_OP) run_alu($urandom);
            else run_mem(op, a, $urandom, $urandom, $urandom_range(4, 0), $urandom_range(2, 0));
        end
        check_eq("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
